// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the priority/round-robin arbiter.
// Holds the FSM state encoding and the index-to-one-hot conversion.
package prio_pkg;

  localparam int N_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_MAX-1:0] onehot_of(input int unsigned idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_arbiter_pick.sv
// Combinational winner search: rotate requests by the start pointer,
// scan from the top bit down, then map the hit back to a real index.
module prio_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         rr_en,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] w_rot;
  int           w_base;
  int           w_hit;
  int           w_pos;

  always_comb begin
    w_base = rr_en ? int'(start) : 0;
    w_rot  = '0;
    w_hit  = 0;
    w_pos  = 0;
    any    = 1'b0;
    // Rotated bit N-1 is request (start-1) mod N, so the previous winner lands at bit 0.
    for (int j = 0; j < N; j++) begin
      w_pos = j + w_base;
      if (w_pos >= N) w_pos = w_pos - N;
      w_rot[j] = req[w_pos];
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (!any && w_rot[j]) begin
        any   = 1'b1;
        w_hit = j;
      end
    end
    w_pos = w_hit + w_base;
    if (w_pos >= N) w_pos = w_pos - N;
    idx = W'(w_pos);
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed or round-robin selection, winner held
// under a valid/ready handshake with back-to-back regrant on acceptance.
module prio_arbiter
  import prio_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_valid;
  logic [W-1:0] r_last;

  logic [W-1:0] w_start;
  logic [W-1:0] w_pick_idx;
  logic         w_pick_any;
  logic         w_accept;
  logic         w_load;
  logic         w_clear;

  // On acceptance the just-accepted winner becomes the new pointer in the same cycle.
  assign w_accept = (r_state == HOLD) && out_ready;
  assign w_start  = (r_state == HOLD) ? r_idx : r_last;

  prio_pick #(.N(N), .W(W)) u_pick (
    .req   (req),
    .start (w_start),
    .rr_en (rr_mode),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = HOLD;
      HOLD:    if (out_ready && !w_pick_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE: w_load = w_pick_any;
      HOLD: begin
        w_load  = out_ready && w_pick_any;
        w_clear = out_ready && !w_pick_any;
      end
      default: w_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_last   <= '0;
    end else begin
      if (w_accept) r_last <= r_idx;
      if (w_load) begin
        r_idx    <= w_pick_idx;
        r_onehot <= N'(onehot_of(int'(w_pick_idx)));
        r_valid  <= 1'b1;
      end else if (w_clear) begin
        r_onehot <= '0;
        r_valid  <= 1'b0;
      end
    end
  end

  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_valid  = r_valid;

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered successor to the team's 4-to-2 combinational priority encoder. Samples an N-bit request vector and selects one winner, by fixed priority (highest index wins) or by round-robin. It presents the winner as a binary index plus one-hot vector under a valid/ready handshake, and holds it stable until it is accepted. Sits between request sources, such as interrupt lines or channel requests, and a single downstream consumer.

## Interface
- `N`, default 4: number of request lines, 2..32.
- `W`, default `$clog2(N)`: index width; derived, never overridden.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  request vector; level-sensitive, no handshake on the input side.
- `rr_mode`  in  1  0 = fixed priority, 1 = round-robin; sampled only at selection instants.
- `out_idx`  out  W  binary index of the winner.
- `out_onehot`  out  N  one-hot form of `out_idx`; all-zero when `out_valid`=0.
- `out_valid`  out  1  a winner is presented.
- `out_ready`  in  1  the consumer accepts the presented winner.

## Operation
- Two states, encoded in `prio_pkg::state_t`:
  - IDLE: no winner is held.
  - HOLD: a winner is presented.
- IDLE:
  - If `req`≠0, compute the winner, register `out_idx`/`out_onehot`, set `out_valid`=1 and go to HOLD.
  - Otherwise stay in IDLE.
- HOLD:
  - All outputs are frozen. Changes on `req` are ignored, including deassertion of the winning line.
  - On `out_ready`=1, set `last` = `out_idx` (the transfer has occurred).
  - If `req`≠0 in the same cycle, select a new winner and stay in HOLD. This is back-to-back operation with no bubble.
  - If `req`=0 in the same cycle, clear `out_valid`/`out_onehot` and go to IDLE.
- Fixed priority: search order is N-1, N-2, …, 0. For N=4 this matches the existing encoder (Y3 highest).
- Round-robin: search order is last-1, last-2, …, 0, N-1, …, last, taken modulo N. The previous winner has the lowest priority.
- Selection in both modes:
  - The first set bit in the search order wins.
  - The round-robin pointer `last` is W bits and is updated only on accepted transfers.
  - In fixed mode, `last` is still updated on accepted transfers but is not used for selection.
  - In round-robin mode, the back-to-back selection uses the `last` value being written in that same cycle, i.e. the winner just accepted.
- Reset, asynchronous: state=IDLE, `out_valid`=0, `out_idx`=0, `out_onehot`=0, `last`=0. Because `last` resets to 0, the first round-robin search order equals the fixed order.
- Reset while in HOLD drops the held winner immediately; no transfer is counted.
- `rr_mode` toggling while in HOLD has no effect until the next selection.

## Timing
- Latency: `req` sampled at edge k → `out_valid`=1 after edge k; the winner is visible in cycle k+1.
- Throughput: one grant per cycle while `out_ready`=1 and `req`≠0.
- The transfer edge is the edge where `out_valid`&`out_ready`=1.
- All outputs are driven directly from flops; there is no combinational path from `req` or `out_ready` to any output.
- `out_ready` while `out_valid`=0 is ignored.

## Structure
- Package `prio_pkg`:
  - `state_t` enum {IDLE, HOLD}.
  - Function `onehot_of(idx)`.
  - Constant `N_MAX`=32.
- Sub-module `prio_pick`, purely combinational:
  - Inputs: `req`, `start`, `rr_en`.
  - Outputs: `idx`, `any`.
  - Implementation: rotate `req` by `start`, then fixed descending search, then un-rotate.
- Top level holds the FSM, output registers and `last` register. Estimated 150–250 lines in total.

## Test plan
- Reset/idle: `rst_n`=0 then 1 with `req`=0 → `out_valid`=0, `out_idx`=0, `out_onehot`=0 for 5 cycles.
- Fixed priority, N=4, `out_ready`=1: apply `req`=0001, 0010, 0100, 1000, 1111 one cycle each → `out_idx`=0, 1, 2, 3, 3, each one cycle later.
- Hold: `req`=1010, `out_ready`=0 for 4 cycles, then `req`=0001 → `out_idx` stays 3 and `out_valid` stays 1 until `out_ready`=1.
- Round-robin: `rr_mode`=1, `req`=1111 held, `out_ready`=1 → grants 3, 2, 1, 0, 3 on consecutive cycles with no bubbles.
- Round-robin with mixed requests: after a grant of 3, `req`=1001 → next grant 0, then 3.
- Mid-HOLD reset: assert `rst_n`=0 asynchronously while `out_valid`=1 → `out_valid` drops before the next edge; after release, with `rr_mode`=1 and `req`=0110, the grant is 2 (pointer reset).
